detect_programmable_sequence: RTL and testbench
===============================================

# detect_programmable_sequence

Runtime-programmable serial bit-pattern detector. It generalises the fixed-pattern sequence FSMs to any pattern of length 1..MAX_LEN, loaded at run time. It adds an input qualifier, a selectable overlapping/non-overlapping match mode and a saturating match counter. It sits on a single-bit serial stream and reports each match as a one-cycle Moore-style pulse.

## Interface
- MAX_LEN, default 8: maximum pattern length in bits (≥2).
- CNT_W, default 8: width of the match counter.
- LEN_W, derived as $clog2(MAX_LEN+1), not overridable: width of the length field.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset; one clock, asynchronous, active-high; asserts immediately, releases synchronously to clk.
- a  in  1  serial data bit.
- a_valid  in  1  a is sampled only on edges where a_valid=1.
- cfg_we  in  1  load configuration on this edge.
- cfg_pattern  in  MAX_LEN  pattern; first-received bit at cfg_pattern[len-1], last at [0].
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping matches counted; 0 = non-overlapping.
- detected  out  1  registered match pulse.
- match_count  out  CNT_W  matches since last reset/config, saturating.

## Operation
- Registers: pattern, len, overlap, history shift register hist[MAX_LEN-1:0], fill counter (LEN_W bits, saturating at len), detected, match_count.
- State is two-level:
  - DISABLED: len==0.
  - ARMED: len≥1. Within ARMED, fill<len means "collecting" and fill==len means "window valid".
- Reset values: pattern=0, len=0 (DISABLED), overlap=1, hist=0, fill=0, detected=0, match_count=0.
- Config (cfg_we=1): pattern<=cfg_pattern; len<=min(cfg_len, MAX_LEN); overlap<=cfg_overlap; hist<=0; fill<=0; match_count<=0; detected<=0.
- cfg_we has priority over a_valid on the same edge. The data bit on that edge is dropped.
- Sample (a_valid=1, cfg_we=0, len≥1):
  - hist<={hist[MAX_LEN-2:0], a}.
  - fill_next=min(fill+1, len).
  - match = (fill_next==len) && (new hist[len-1:0] == pattern[len-1:0]); bits above len-1 are ignored.
- On match:
  - detected<=1.
  - match_count<=match_count+1, saturating at 2^CNT_W-1.
  - If overlap=0, fill<=0, so the next match needs len fresh bits. If overlap=1, fill stays at len.
- No match, idle cycle (a_valid=0), or DISABLED: detected<=0. hist, fill and the counter hold on idle cycles.
- DISABLED: samples ignored; no match ever.
- len=1: each sampled bit equal to pattern[0] is a match.

## Timing
- Latency: detected rises in the cycle after the edge that samples the final pattern bit. It is high for exactly one cycle per match.
- Back-to-back matches on consecutive sampled edges (overlap=1, e.g. pattern 11, len 2, input 111) keep detected high on consecutive cycles.
- match_count updates on the same edge as detected.
- Asynchronous rst mid-stream returns every register to its reset value immediately; partial matches are lost.
- Config mid-stream discards the partial match; the first possible detection is len sampled bits after the config edge.

## Structure
- Package seq_det_pkg holds:
  - typedef seq_mode_t (SEQ_OVERLAP, SEQ_NONOVERLAP).
  - function clamp_len.
  - function match_mask(len) giving a MAX_LEN-bit mask with the low len bits set.
- One sub-module, seq_window_compare (combinational): takes hist, pattern and len; returns an equality flag over the masked window.
- Top level holds all registers and control.

## Test plan
1. Pattern 110011, len 6, overlap=1; stream 0011_0101_1001_1001_1010_1000, MSB first, a_valid=1 → detected high after sampled bits 12 and 16 (0-indexed); match_count=2.
2. Same stream, overlap=0 → single pulse after bit 12; the bit-16 match is suppressed; match_count=1.
3. Pattern 1010, len 4, overlap=1, same stream → pulses after bits 6, 19 and 21; count=3. Repeat with a_valid=0 on alternate cycles carrying garbage a → identical pulses, in sample order.
4. cfg_len=15 with MAX_LEN=8 → len reads as 8. cfg_len=0 → no detection on a stream of all ones. cfg_we together with a_valid=1 → that bit is dropped and count is cleared.
5. CNT_W=2, pattern 1, len 1, ten ones → detected high for ten cycles; match_count saturates at 3.
6. rst asserted asynchronously (mid-clock) after 5 of 6 pattern bits → detected=0 and count=0 immediately, len=0. Reconfigure and send the full pattern → exactly one pulse.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
package seq_det_pkg;

    // Match-mode encoding; the value matches the cfg_overlap input bit.
    typedef enum logic {
        SEQ_NONOVERLAP = 1'b0,
        SEQ_OVERLAP    = 1'b1
    } seq_mode_t;

    // Widest mask match_mask can build; callers cast down to their own width.
    localparam int SEQ_MASK_MAX = 64;

    // Limit a requested pattern length to the largest length the hardware holds.
    function automatic int clamp_len(input int len, input int max_len);
        return (len > max_len) ? max_len : len;
    endfunction

    // Mask with the low len bits set: selects the live part of the history window.
    function automatic logic [SEQ_MASK_MAX-1:0] match_mask(input int len);
        logic [SEQ_MASK_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < SEQ_MASK_MAX; i++) begin
            if (i < len) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_window_compare.sv
// Combinational compare of the newest len history bits against the pattern.
module seq_window_compare
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic [MAX_LEN-1:0] hist,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               equal
);

    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] diff;

    // Bits at or above len are outside the window and never count as a mismatch.
    assign mask = MAX_LEN'(match_mask(int'(len)));

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_bit
            assign diff[gi] = mask[gi] & (hist[gi] ^ pattern[gi]);
        end
    endgenerate

    assign equal = ~|diff;

endmodule

// File: rtl/detect_programmable_sequence.sv
// Runtime-programmable serial bit-pattern detector with qualifier, overlap mode
// and saturating match counter. Match pulse is registered (one cycle after the
// edge that samples the final pattern bit).
module detect_programmable_sequence
    import seq_det_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a,
    input  logic               a_valid,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count
);

    logic [MAX_LEN-1:0] pattern_reg;
    logic [LEN_W-1:0]   len_reg;
    seq_mode_t          overlap_reg;
    logic [MAX_LEN-1:0] hist_reg;
    logic [LEN_W-1:0]   fill_reg;
    logic               detected_reg;
    logic [CNT_W-1:0]   match_count_reg;

    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   fill_next;
    logic [LEN_W-1:0]   cfg_len_clamped;
    logic               armed;
    logic               window_equal;
    logic               match_hit;
    logic               count_full;

    // Next-state terms for a sampled bit; only used when a sample is accepted.
    assign armed           = (len_reg != '0);
    assign hist_next       = {hist_reg[MAX_LEN-2:0], a};
    assign fill_next       = (fill_reg >= len_reg) ? len_reg : fill_reg + LEN_W'(1);
    assign cfg_len_clamped = LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
    assign count_full      = &match_count_reg;

    seq_window_compare #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_compare (
        .hist    (hist_next),
        .pattern (pattern_reg),
        .len     (len_reg),
        .equal   (window_equal)
    );

    // A match needs a full window of fresh bits and an equal masked compare.
    assign match_hit = armed && (fill_next == len_reg) && window_equal;

    // Configuration, sampling, match pulse and counter; config wins over data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_reg     <= '0;
            len_reg         <= '0;
            overlap_reg     <= SEQ_OVERLAP;
            hist_reg        <= '0;
            fill_reg        <= '0;
            detected_reg    <= 1'b0;
            match_count_reg <= '0;
        end else if (cfg_we) begin
            pattern_reg     <= cfg_pattern;
            len_reg         <= cfg_len_clamped;
            overlap_reg     <= seq_mode_t'(cfg_overlap);
            hist_reg        <= '0;
            fill_reg        <= '0;
            detected_reg    <= 1'b0;
            match_count_reg <= '0;
        end else if (a_valid && armed) begin
            hist_reg     <= hist_next;
            detected_reg <= match_hit;
            if (match_hit) begin
                if (!count_full) begin
                    match_count_reg <= match_count_reg + CNT_W'(1);
                end
                // Non-overlapping mode restarts collection so the next match
                // is built entirely from bits after this one.
                fill_reg <= (overlap_reg == SEQ_NONOVERLAP) ? '0 : fill_next;
            end else begin
                fill_reg <= fill_next;
            end
        end else begin
            detected_reg <= 1'b0;
        end
    end

    assign detected    = detected_reg;
    assign match_count = match_count_reg;

endmodule

// File: tb/tb_detect_programmable_sequence.sv
// Self-checking bench for detect_programmable_sequence: table vectors from the
// documented scenarios, hand-written corner sequences, and randomized traffic
// compared against a queue-based reference model.
module tb_detect_programmable_sequence;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               a;
    logic               a_valid;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               detected;
    logic [7:0]         match_count;
    logic               detected_s;
    logic [1:0]         match_count_s;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: bits sampled since the last config/reset.
    int       m_len;
    logic [7:0] m_pat;
    bit       m_ovl;
    int       m_q[$];
    int       m_last;
    bit       m_det;
    int       m_cnt8;
    int       m_cnt2;

    always #5 clk = ~clk;

    detect_programmable_sequence #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .a_valid     (a_valid),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .detected    (detected),
        .match_count (match_count)
    );

    detect_programmable_sequence #(.MAX_LEN(8), .CNT_W(2)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .a_valid     (a_valid),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .detected    (detected_s),
        .match_count (match_count_s)
    );

    typedef struct {
        logic [7:0]  pat;
        logic [3:0]  len;
        bit          ovl;
        logic [23:0] stream;  // MSB is the first sampled bit
        bit          alt;     // insert an idle garbage cycle before each sample
        logic [23:0] pulses;  // bit i set: detected expected after sample i
        int          count;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_len  = 0;
        m_pat  = '0;
        m_ovl  = 1'b1;
        m_q.delete();
        m_last = 0;
        m_det  = 1'b0;
        m_cnt8 = 0;
        m_cnt2 = 0;
    endtask

    // Match rule from the behaviour description: last len samples equal the
    // pattern (first bit at pattern[len-1]); non-overlap needs len samples
    // since the previous match.
    task automatic model_clock(input logic ai, input logic vi, input logic wi,
                               input logic [7:0] pi, input int li, input logic oi);
        int  n;
        bit  hit;
        if (wi) begin
            m_len  = (li > MAX_LEN) ? MAX_LEN : li;
            m_pat  = pi;
            m_ovl  = oi;
            m_q.delete();
            m_last = 0;
            m_det  = 1'b0;
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else if (vi && m_len > 0) begin
            m_q.push_back(int'(ai));
            n   = m_q.size();
            hit = (n >= m_len) && (m_ovl || (n - m_last) >= m_len);
            if (hit) begin
                for (int k = 0; k < m_len; k++) begin
                    if (m_q[n - m_len + k] != int'(m_pat[m_len - 1 - k])) hit = 1'b0;
                end
            end
            m_det = hit;
            if (hit) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
                m_last = n;
            end
        end else begin
            m_det = 1'b0;
        end
    endtask

    // One clock: drive inputs, advance the model, compare just after the edge.
    task automatic step(input logic ai, input logic vi, input logic wi);
        a       = ai;
        a_valid = vi;
        cfg_we  = wi;
        @(posedge clk);
        model_clock(ai, vi, wi, cfg_pattern, int'(cfg_len), cfg_overlap);
        #1;
        check("det", int'(detected), int'(m_det));
        check("cnt", int'(match_count), m_cnt8);
        check("det_s", int'(detected_s), int'(m_det));
        check("cnt_s", int'(match_count_s), m_cnt2);
    endtask

    task automatic configure(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        step(1'b0, 1'b0, 1'b1);
    endtask

    // Assert rst between edges and check outputs clear before any clock edge.
    task automatic async_reset();
        a_valid = 1'b0;
        cfg_we  = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_det", int'(detected), 0);
        check("rst_cnt", int'(match_count), 0);
        check("rst_cnt_s", int'(match_count_s), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int pulses_seen;
        logic [5:0] p6;

        rst         = 1'b1;
        a           = 1'b0;
        a_valid     = 1'b0;
        cfg_we      = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        model_reset();

        tbl[0] = '{pat: 8'h33, len: 4'd6,  ovl: 1'b1, stream: 24'h359A8_8 >> 0, alt: 1'b0, pulses: 24'h011000, count: 2};
        tbl[0].stream = 24'b0011_0101_1001_1001_1010_1000;
        tbl[1] = '{pat: 8'h33, len: 4'd6,  ovl: 1'b0, stream: 24'b0011_0101_1001_1001_1010_1000, alt: 1'b0, pulses: 24'h001000, count: 1};
        tbl[2] = '{pat: 8'h0A, len: 4'd4,  ovl: 1'b1, stream: 24'b0011_0101_1001_1001_1010_1000, alt: 1'b0, pulses: 24'h280040, count: 3};
        tbl[3] = '{pat: 8'h0A, len: 4'd4,  ovl: 1'b1, stream: 24'b0011_0101_1001_1001_1010_1000, alt: 1'b1, pulses: 24'h280040, count: 3};
        tbl[4] = '{pat: 8'hFF, len: 4'd15, ovl: 1'b0, stream: 24'hFFFFFF, alt: 1'b0, pulses: 24'h808080, count: 3};
        tbl[5] = '{pat: 8'hFF, len: 4'd15, ovl: 1'b1, stream: 24'hFFFFFF, alt: 1'b0, pulses: 24'hFFFF80, count: 17};
        tbl[6] = '{pat: 8'hFF, len: 4'd0,  ovl: 1'b1, stream: 24'hFFFFFF, alt: 1'b0, pulses: 24'h000000, count: 0};

        // Reset state, then release synchronously.
        #1;
        check("reset_det", int'(detected), 0);
        check("reset_cnt", int'(match_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Disabled after reset: ones never match.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);

        // Table-driven scenarios.
        for (int i = 0; i < 7; i++) begin
            configure(tbl[i].pat, tbl[i].len, tbl[i].ovl);
            for (int b = 0; b < 24; b++) begin
                if (tbl[i].alt) begin
                    step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
                    check($sformatf("tbl%0d_idle%0d", i, b), int'(detected), 0);
                end
                step(tbl[i].stream[23 - b], 1'b1, 1'b0);
                check($sformatf("tbl%0d_bit%0d", i, b), int'(detected), int'(tbl[i].pulses[b]));
            end
            check($sformatf("tbl%0d_count", i), int'(match_count), tbl[i].count);
        end

        // Config on the same edge as a valid bit: the bit is dropped, count clears.
        configure(8'h03, 4'd2, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("pre_drop_cnt", int'(match_count), 1);
        step(1'b1, 1'b1, 1'b1);
        check("drop_cnt", int'(match_count), 0);
        step(1'b1, 1'b1, 1'b0);
        check("drop_no_match", int'(detected), 0);
        step(1'b1, 1'b1, 1'b0);
        check("drop_then_match", int'(detected), 1);

        // Saturation of the 2-bit counter with len=1.
        configure(8'h01, 4'd1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b1, 1'b0);
            check($sformatf("sat_det%0d", k), int'(detected_s), 1);
            check($sformatf("sat_cnt%0d", k), int'(match_count_s), (k + 1 < 3) ? k + 1 : 3);
        end

        // Asynchronous reset while a pulse is high.
        p6 = 6'b110011;
        configure(8'h33, 4'd6, 1'b1);
        for (int k = 5; k >= 0; k--) step(p6[k], 1'b1, 1'b0);
        check("pre_rst_det", int'(detected), 1);
        async_reset();

        // Asynchronous reset after 5 of 6 bits; partial match is lost and len=0.
        configure(8'h33, 4'd6, 1'b1);
        for (int k = 5; k >= 1; k--) step(p6[k], 1'b1, 1'b0);
        async_reset();
        pulses_seen = 0;
        for (int k = 5; k >= 0; k--) begin
            step(p6[k], 1'b1, 1'b0);
            pulses_seen += int'(detected);
        end
        check("post_rst_disabled", pulses_seen, 0);
        configure(8'h33, 4'd6, 1'b1);
        pulses_seen = 0;
        for (int k = 5; k >= 0; k--) begin
            step(p6[k], 1'b1, 1'b0);
            pulses_seen += int'(detected);
        end
        check("reconfig_pulses", pulses_seen, 1);
        check("reconfig_cnt", int'(match_count), 1);

        // Randomized traffic against the model.
        for (int r = 0; r < 20; r++) begin
            logic [3:0] rl;
            rl = (r % 4 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
            configure(8'($urandom), rl, 1'($urandom_range(0, 1)));
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 299) == 0) begin
                    async_reset();
                end else begin
                    step(1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 99) < 70),
                         1'($urandom_range(0, 99) == 0));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
